frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Controller that sequences one processing frame through the ColorChord back end: NoteFinder, then linear visualizer, then LED driver.
- Decimates the DFT's per-sample read pulse into frame triggers.
- Launches each stage with a one-cycle start pulse and waits for that stage's completion.
- Drops triggers that arrive while a frame is in flight, counts them as overruns, and recovers from a hung stage through a watchdog.

Parameters:
- NF_START_DELAY, 4: cycles from a triggering sampleRead to the nfStart pulse, so the DFT bins can settle; legal range 1..15.
- FRAME_DIV, 16: number of sampleRead pulses per frame trigger; legal range 1..65535.
- TIMEOUT, 1048575: maximum cycles the sequencer may spend in any single wait state before it aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sampleRead  in  1  one-cycle pulse from the DFT when it consumes an audio sample
- nfStart  out  1  one-cycle start pulse to NoteFinder
- nfFinished  in  1  NoteFinder completion; level or pulse accepted
- visStart  out  1  one-cycle start pulse to the visualizer
- visDone  in  1  visualizer completion
- ledStart  out  1  one-cycle start pulse to LEDDriver2
- ledDone  in  1  LED driver completion
- busy  out  1  high whenever state is not IDLE
- frameCount  out  16  number of frames completed; wraps modulo 2^16
- overrunCount  out  8  number of dropped triggers; saturates at 255
- timeoutErr  out  1  sticky flag, set by a watchdog abort

Behaviour:
- Reset values, held while rst is high: state IDLE, all outputs 0, divider 0, delay counter 0, watchdog 0. A reset asserted mid-frame aborts the frame immediately, and no start pulse is emitted in the cycle after reset.
- Divider:
  - Counts sampleRead pulses 0..FRAME_DIV-1 and runs in every state.
  - A trigger occurs on a sampleRead cycle when the divider equals FRAME_DIV-1; the divider then returns to 0.
  - With FRAME_DIV=1, every sampleRead is a trigger.
- States: IDLE, DELAY, NF_RUN, VIS_RUN, LED_RUN.
- IDLE:
  - On a trigger at cycle t, go to DELAY.
  - nfStart is high for exactly the single cycle t+NF_START_DELAY, and the state enters NF_RUN in the same cycle.
- NF_RUN:
  - When nfFinished is sampled high at cycle u, visStart is high in cycle u+1 and the state is VIS_RUN from u+1.
  - An nfFinished that coincides with the nfStart cycle is ignored.
- VIS_RUN: visDone sampled high at u gives ledStart high in u+1 and state LED_RUN.
- LED_RUN: ledDone sampled high at u gives frameCount+1 and state IDLE, both visible in u+1.
- Done inputs are ignored in every state except their own.
- Only one start output is ever high in a given cycle.
- Overrun:
  - A trigger in any state other than IDLE is dropped and increments overrunCount by 1, saturating at 255.
  - This includes a trigger in the same cycle as ledDone.
  - The divider keeps counting normally.
- Watchdog:
  - Clears on every state change and counts cycles spent in NF_RUN, VIS_RUN or LED_RUN.
  - When it reaches TIMEOUT: set timeoutErr, go to IDLE in the next cycle, do not increment frameCount, emit no pulse.
  - timeoutErr clears only on rst.
- A trigger in the cycle the state returns to IDLE (u+1 after ledDone) is accepted normally.
- busy rises in the cycle after the accepted trigger and falls in the cycle the state returns to IDLE.

Test Plan:
1. Basic frame timing (FRAME_DIV=1, NF_START_DELAY=4): sampleRead pulse at cycle 10; nfFinished at 20; visDone at 25; ledDone at 40.
   Required: nfStart high only at 14, visStart only at 21, ledStart only at 26; frameCount=1 and busy=0 at 41.
2. Decimation (FRAME_DIV=16): 48 sampleRead pulses with stages completing quickly.
   Required: exactly 3 nfStart pulses, on the 16th, 32nd and 48th reads (each +4 cycles); frameCount=3.
3. Overrun: trigger, then hold nfFinished low across 300 further triggers.
   Required: overrunCount saturates at 255; releasing nfFinished completes the frame with frameCount=1.
4. Timeout (TIMEOUT=100): trigger and never assert nfFinished.
   Required: timeoutErr=1 and IDLE 100 cycles after entering NF_RUN; frameCount=0; the next trigger starts a fresh frame normally.
5. Spurious and simultaneous inputs: pulse visDone and ledDone while in IDLE and NF_RUN, and raise a trigger in the same cycle as ledDone.
   Required: no state change from the spurious pulses; overrunCount increments by 1.
6. Reset mid-operation: assert rst for 1 cycle while in VIS_RUN.
   Required: all outputs 0; divider restarts at 0, so with FRAME_DIV=16 the next nfStart follows the 16th post-reset read; no stray visStart or ledStart.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the ColorChord back-end stages.
// master is the sequencer side; slave is the DFT/NoteFinder/visualizer/LED side.
interface frame_sequencer_if;
  logic        sampleRead;
  logic        nfStart;
  logic        nfFinished;
  logic        visStart;
  logic        visDone;
  logic        ledStart;
  logic        ledDone;
  logic        busy;
  logic [15:0] frameCount;
  logic [7:0]  overrunCount;
  logic        timeoutErr;

  modport master (
    input  sampleRead, nfFinished, visDone, ledDone,
    output nfStart, visStart, ledStart, busy, frameCount, overrunCount, timeoutErr
  );

  modport slave (
    output sampleRead, nfFinished, visDone, ledDone,
    input  nfStart, visStart, ledStart, busy, frameCount, overrunCount, timeoutErr
  );
endinterface

// File: rtl/frame_sequencer.sv
// Sequences one frame through NoteFinder -> visualizer -> LED driver, triggered by a
// decimated DFT sample pulse, with overrun counting and a per-stage watchdog.
module frame_sequencer #(
  parameter int NF_START_DELAY = 4,
  parameter int FRAME_DIV      = 16,
  parameter int TIMEOUT        = 1048575
) (
  input  logic clk,
  input  logic rst,
  frame_sequencer_if.master bus
);

  localparam int              WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [15:0]     DIV_LAST   = 16'(FRAME_DIV - 1);
  localparam logic [3:0]      DELAY_LAST = 4'(NF_START_DELAY - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DELAY, NF_RUN, VIS_RUN, LED_RUN} state_t;

  state_t            r_state;
  logic [15:0]       r_div;
  logic [3:0]        r_delay;
  logic [WD_W-1:0]   r_wd;
  logic              r_nfStart;
  logic              r_visStart;
  logic              r_ledStart;
  logic              r_busy;
  logic              r_timeoutErr;
  logic [15:0]       r_frameCount;
  logic [7:0]        r_overrunCount;

  logic w_trigger;
  logic w_running;
  logic w_done;

  assign w_trigger = bus.sampleRead && (r_div == DIV_LAST);
  assign w_running = r_state inside {NF_RUN, VIS_RUN, LED_RUN};
  // nfFinished in the nfStart cycle belongs to the previous frame's level, so it is ignored
  assign w_done    = ((r_state == NF_RUN)  && bus.nfFinished && !r_nfStart) ||
                     ((r_state == VIS_RUN) && bus.visDone) ||
                     ((r_state == LED_RUN) && bus.ledDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (bus.sampleRead) begin
      r_div <= w_trigger ? 16'd0 : r_div + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_delay        <= '0;
      r_wd           <= '0;
      r_nfStart      <= 1'b0;
      r_visStart     <= 1'b0;
      r_ledStart     <= 1'b0;
      r_busy         <= 1'b0;
      r_timeoutErr   <= 1'b0;
      r_frameCount   <= '0;
      r_overrunCount <= '0;
    end else begin
      r_nfStart  <= 1'b0;
      r_visStart <= 1'b0;
      r_ledStart <= 1'b0;

      if (w_trigger && (r_state != IDLE) && (r_overrunCount != 8'hFF))
        r_overrunCount <= r_overrunCount + 8'd1;

      // Watchdog only runs while waiting on a stage; expiry abandons the frame silently
      if (w_running && !w_done) begin
        if (r_wd == WD_LAST) begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_timeoutErr <= 1'b1;
          r_wd         <= '0;
        end else begin
          r_wd <= r_wd + WD_W'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_busy <= 1'b1;
            r_wd   <= '0;
            if (NF_START_DELAY == 1) begin
              r_state   <= NF_RUN;
              r_nfStart <= 1'b1;
            end else begin
              r_state <= DELAY;
              r_delay <= 4'd1;
            end
          end
        end
        DELAY: begin
          if (r_delay == DELAY_LAST) begin
            r_state   <= NF_RUN;
            r_nfStart <= 1'b1;
          end else begin
            r_delay <= r_delay + 4'd1;
          end
        end
        NF_RUN: begin
          if (w_done) begin
            r_state    <= VIS_RUN;
            r_visStart <= 1'b1;
            r_wd       <= '0;
          end
        end
        VIS_RUN: begin
          if (w_done) begin
            r_state    <= LED_RUN;
            r_ledStart <= 1'b1;
            r_wd       <= '0;
          end
        end
        LED_RUN: begin
          if (w_done) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frameCount <= r_frameCount + 16'd1;
            r_wd         <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nfStart      = r_nfStart;
  assign bus.visStart     = r_visStart;
  assign bus.ledStart     = r_ledStart;
  assign bus.busy         = r_busy;
  assign bus.frameCount   = r_frameCount;
  assign bus.overrunCount = r_overrunCount;
  assign bus.timeoutErr   = r_timeoutErr;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: two instances (FRAME_DIV=1 and FRAME_DIV=16/TIMEOUT=100)
// receive identical stimulus; each scenario observes the instance matching its parameters.
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  frame_sequencer_if sa ();
  frame_sequencer_if sb ();

  frame_sequencer #(.NF_START_DELAY(4), .FRAME_DIV(1), .TIMEOUT(1000)) dutA (
    .clk(clk), .rst(rst), .bus(sa.master)
  );

  frame_sequencer #(.NF_START_DELAY(4), .FRAME_DIV(16), .TIMEOUT(100)) dutB (
    .clk(clk), .rst(rst), .bus(sb.master)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc, nfCnt, visCnt, ledCnt, nfAt, visAt, ledAt;
  int multiStart  = 0;
  int nfTimes [3];
  bit selB;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    cyc = 0; nfCnt = 0; visCnt = 0; ledCnt = 0; nfAt = -1; visAt = -1; ledAt = -1;
    for (int i = 0; i < 3; i++) nfTimes[i] = -1;
  endtask

  // Drive one cycle of inputs on both instances, then log start pulses of the next cycle
  task automatic applyStimulus(input bit sr, input bit nf, input bit vd, input bit ld);
    logic ns, vs, ls;
    sa.sampleRead = sr; sa.nfFinished = nf; sa.visDone = vd; sa.ledDone = ld;
    sb.sampleRead = sr; sb.nfFinished = nf; sb.visDone = vd; sb.ledDone = ld;
    @(posedge clk); #1;
    cyc++;
    ns = selB ? sb.nfStart  : sa.nfStart;
    vs = selB ? sb.visStart : sa.visStart;
    ls = selB ? sb.ledStart : sa.ledStart;
    if (ns) begin
      if (nfCnt < 3) nfTimes[nfCnt] = cyc;
      nfCnt++;
      nfAt = cyc;
    end
    if (vs) begin visCnt++; visAt = cyc; end
    if (ls) begin ledCnt++; ledAt = cyc; end
    if ((int'(sa.nfStart) + int'(sa.visStart) + int'(sa.ledStart) > 1) ||
        (int'(sb.nfStart) + int'(sb.visStart) + int'(sb.ledStart) > 1))
      multiStart++;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    sa.sampleRead = 0; sa.nfFinished = 0; sa.visDone = 0; sa.ledDone = 0;
    sb.sampleRead = 0; sb.nfFinished = 0; sb.visDone = 0; sb.ledDone = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clearCounts();
  endtask

  initial begin
    selB = 1'b0;
    applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset busy",       sa.busy, 0);
    checkOutput("reset frameCount", sa.frameCount, 0);
    checkOutput("reset overrun",    sa.overrunCount, 0);
    checkOutput("reset timeoutErr", sb.timeoutErr, 0);
    checkOutput("reset starts",     {sa.nfStart, sa.visStart, sa.ledStart}, 0);

    // Basic frame timing on FRAME_DIV=1
    applyReset();
    for (int c = 0; c <= 40; c++) applyStimulus(c == 10, c == 20, c == 25, c == 40);
    checkOutput("t1 nfStart count",  nfCnt, 1);
    checkOutput("t1 nfStart cycle",  nfAt, 14);
    checkOutput("t1 visStart count", visCnt, 1);
    checkOutput("t1 visStart cycle", visAt, 21);
    checkOutput("t1 ledStart count", ledCnt, 1);
    checkOutput("t1 ledStart cycle", ledAt, 26);
    checkOutput("t1 frameCount",     sa.frameCount, 1);
    checkOutput("t1 busy",           sa.busy, 0);

    // Overrun saturation with NoteFinder stalled
    applyReset();
    for (int c = 0; c <= 300; c++) applyStimulus(1, 0, 0, 0);
    checkOutput("t3 overrun sat", sa.overrunCount, 255);
    checkOutput("t3 busy stalled", sa.busy, 1);
    checkOutput("t3 no visStart", visCnt, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3 frameCount", sa.frameCount, 1);
    checkOutput("t3 busy done",  sa.busy, 0);
    checkOutput("t3 timeoutErr", sa.timeoutErr, 0);

    // Spurious done pulses and a trigger coinciding with ledDone
    applyReset();
    for (int c = 0; c <= 15; c++) begin
      applyStimulus(c == 3 || c == 14 || c == 15,
                    c == 7 || c == 12,
                    c == 0 || c == 1 || c == 9 || c == 13,
                    c == 1 || c == 2 || c == 10 || c == 14);
      if (c == 2) begin
        checkOutput("t5 idle spurious busy", sa.busy, 0);
        checkOutput("t5 idle spurious vis",  visCnt + ledCnt, 0);
      end
      if (c == 11) begin
        checkOutput("t5 nfStart count",       nfCnt, 1);
        checkOutput("t5 nfStart cycle",       nfAt, 7);
        checkOutput("t5 nf spurious starts",  visCnt + ledCnt, 0);
        checkOutput("t5 nf spurious busy",    sa.busy, 1);
      end
      if (c == 14) begin
        checkOutput("t5 visStart cycle", visAt, 13);
        checkOutput("t5 ledStart cycle", ledAt, 14);
        checkOutput("t5 frameCount",     sa.frameCount, 1);
        checkOutput("t5 overrun",        sa.overrunCount, 1);
        checkOutput("t5 busy idle",      sa.busy, 0);
      end
      if (c == 15) begin
        checkOutput("t5 retrigger busy",   sa.busy, 1);
        checkOutput("t5 retrigger overrun", sa.overrunCount, 1);
      end
    end

    // Decimation on FRAME_DIV=16 with stages completing immediately
    selB = 1'b1;
    applyReset();
    for (int c = 0; c <= 209; c++) applyStimulus((c > 0) && (c % 4 == 0) && (c <= 192), 1, 1, 1);
    checkOutput("t2 nfStart count", nfCnt, 3);
    checkOutput("t2 nfStart #1",    nfTimes[0], 68);
    checkOutput("t2 nfStart #2",    nfTimes[1], 132);
    checkOutput("t2 nfStart #3",    nfTimes[2], 196);
    checkOutput("t2 frameCount",    sb.frameCount, 3);
    checkOutput("t2 overrun",       sb.overrunCount, 0);

    // Watchdog abort in NF_RUN with TIMEOUT=100
    applyReset();
    for (int c = 0; c <= 118; c++) applyStimulus((c >= 1) && (c <= 16), 0, 0, 0);
    checkOutput("t4 nfStart cycle",   nfAt, 20);
    checkOutput("t4 busy before",     sb.busy, 1);
    checkOutput("t4 timeoutErr before", sb.timeoutErr, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4 busy after",      sb.busy, 0);
    checkOutput("t4 timeoutErr after", sb.timeoutErr, 1);
    checkOutput("t4 frameCount",      sb.frameCount, 0);
    checkOutput("t4 no stray starts", visCnt + ledCnt, 0);
    clearCounts();
    for (int c = 0; c <= 39; c++) applyStimulus(c < 16, 1, 1, 1);
    checkOutput("t4 fresh nfStart",    nfAt, 19);
    checkOutput("t4 fresh frameCount", sb.frameCount, 1);
    checkOutput("t4 sticky timeoutErr", sb.timeoutErr, 1);

    // Reset asserted for one cycle while in VIS_RUN
    clearCounts();
    for (int c = 0; c <= 49; c++) begin
      rst = (c == 22);
      applyStimulus((c <= 15) || (c == 21) || (c == 22) || ((c >= 23) && (c <= 38)), c == 20, 0, 0);
      if (c == 22) begin
        checkOutput("t6 reset busy",       sb.busy, 0);
        checkOutput("t6 reset frameCount", sb.frameCount, 0);
        checkOutput("t6 reset timeoutErr", sb.timeoutErr, 0);
        checkOutput("t6 reset overrun",    sb.overrunCount, 0);
        checkOutput("t6 reset starts",     {sb.nfStart, sb.visStart, sb.ledStart}, 0);
      end
    end
    rst = 1'b0;
    checkOutput("t6 nfStart count",  nfCnt, 2);
    checkOutput("t6 nfStart cycle",  nfAt, 42);
    checkOutput("t6 visStart count", visCnt, 1);
    checkOutput("t6 ledStart count", ledCnt, 0);

    checkOutput("one start per cycle", multiStart, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
